// File: rtl/finalproj_soc_pio_arbiter_pkg.sv
// Shared types and constants for the PIO round-robin arbiter.
// The optional lock feature is enabled with the PIO_ARB_LOCK_EN macro.
package finalproj_soc_pio_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam int PIO_ARB_MAX_REQ = 8;
  localparam int PIO_ARB_IDX_W   = 3;

  // Round-robin successor of a granted index, wrapping at n-1.
  function automatic logic [PIO_ARB_IDX_W-1:0] rr_next(input logic [PIO_ARB_IDX_W-1:0] g,
                                                      input int n);
    if (int'(g) >= n - 1) begin
      return 3'd0;
    end else begin
      return g + 3'd1;
    end
  endfunction

endpackage

// File: rtl/finalproj_soc_pio_arbiter_if.sv
// Requester-side bus of the PIO arbiter: flattened per-requester request fields
// plus the shared completion signals.
interface finalproj_soc_pio_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic [2:0]              grant_id;
  logic                    busy;

  modport master (output req, req_wr, req_addr, req_wdata,
                  input  ack, rdata, grant_id, busy);
  modport slave  (input  req, req_wr, req_addr, req_wdata,
                  output ack, rdata, grant_id, busy);
endinterface

// File: rtl/finalproj_soc_pio_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping around, returned as an index plus a valid flag.
module finalproj_soc_rr_pick
  import finalproj_soc_pio_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [PIO_ARB_IDX_W-1:0] ptr_i,
  output logic [PIO_ARB_IDX_W-1:0] idx_o,
  output logic                     valid_o
);

  // Scan offsets from the pointer; the smallest offset with a request wins.
  always_comb begin
    idx_o   = PIO_ARB_IDX_W'(0);
    valid_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid_o && req_i[j] && (((int'(ptr_i) + k) % N_REQ) == j)) begin
          idx_o   = PIO_ARB_IDX_W'(j);
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/finalproj_soc_pio_arbiter.sv
// Round-robin arbiter serialising single-beat requests onto one Avalon-MM PIO slave.
// Define PIO_ARB_LOCK_EN to add the lock port that holds a grant across transactions.
module finalproj_soc_pio_arbiter
  import finalproj_soc_pio_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  finalproj_soc_pio_arbiter_if.slave req_if,
  output logic [ADDR_W-1:0]         pio_address_o,
  output logic                      pio_chipselect_o,
  output logic                      pio_write_n_o,
  output logic [DATA_W-1:0]         pio_writedata_o,
  input  logic [DATA_W-1:0]         pio_readdata_i
`ifdef PIO_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]          lock_i
`endif
);

  state_e                   state_q, state_d;
  logic [PIO_ARB_IDX_W-1:0] ptr_q, ptr_d, grant_q, grant_d;
  logic [N_REQ-1:0]         ack_q, ack_d, grant_mask_s, req_eff_s;
  logic [DATA_W-1:0]        rdata_q, rdata_d, wdata_q, wdata_d, sel_wdata_s;
  logic [ADDR_W-1:0]        addr_q, addr_d, sel_addr_s;
  logic                     busy_q, busy_d, cs_q, cs_d, wn_q, wn_d, sel_wr_s;
  logic [PIO_ARB_IDX_W-1:0] pick_idx_s;
  logic                     pick_valid_s;

  // One-hot view of the last grant, and the fields of the picked requester.
  always_comb begin
    grant_mask_s = '0;
    sel_wr_s     = 1'b0;
    sel_addr_s   = '0;
    sel_wdata_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_mask_s[i] = (int'(grant_q) == i);
      if (int'(pick_idx_s) == i) begin
        sel_wr_s    = req_if.req_wr[i];
        sel_addr_s  = req_if.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_s = req_if.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PIO_ARB_LOCK_EN
  logic lock_hold_q, lock_hold_d, lock_cur_s;

  // A held lock narrows the candidate set to the locked requester.
  always_comb begin
    lock_cur_s = |(lock_i & grant_mask_s);
    if (lock_hold_q && lock_cur_s) begin
      req_eff_s = req_if.req & grant_mask_s;
    end else begin
      req_eff_s = req_if.req;
    end
  end
`else
  assign req_eff_s = req_if.req;
`endif

  finalproj_soc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_eff_s),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // FSM next state; bus outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    wn_d    = wn_q;
`ifdef PIO_ARB_LOCK_EN
    lock_hold_d = lock_hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_ISSUE;
          grant_d = pick_idx_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          wn_d    = ~sel_wr_s;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        // write_n still high here means the access in flight is a read.
        if (wn_q) begin
          rdata_d = pio_readdata_i;
        end else begin
          rdata_d = rdata_q;
        end
        ack_d   = grant_mask_s;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
`ifdef PIO_ARB_LOCK_EN
        lock_hold_d = lock_cur_s;
        if (lock_cur_s) begin
          ptr_d = grant_q;
        end else begin
          ptr_d = rr_next(grant_q, N_REQ);
        end
`else
        ptr_d = rr_next(grant_q, N_REQ);
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      grant_q <= 3'd0;
      ack_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
`ifdef PIO_ARB_LOCK_EN
      lock_hold_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
`ifdef PIO_ARB_LOCK_EN
      lock_hold_q <= lock_hold_d;
`endif
    end
  end

  assign req_if.ack      = ack_q;
  assign req_if.rdata    = rdata_q;
  assign req_if.grant_id = grant_q;
  assign req_if.busy     = busy_q;
  assign pio_address_o    = addr_q;
  assign pio_chipselect_o = cs_q;
  assign pio_write_n_o    = wn_q;
  assign pio_writedata_o  = wdata_q;

endmodule

// File: tb/tb_finalproj_soc_pio_arbiter.sv
// Self-checking bench for finalproj_soc_pio_arbiter: directed vector table, hand-written
// reset/contention/lock sequences and randomized traffic against a transaction-level model.
module tb_finalproj_soc_pio_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic [1:0]  pio_addr;
  logic        pio_cs, pio_wn;
  logic [31:0] pio_wdata, pio_rdata;
  logic [31:0] pio_mem [4];
`ifdef PIO_ARB_LOCK_EN
  logic [N-1:0] lock = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  finalproj_soc_pio_arbiter_if #(.N_REQ(N), .ADDR_W(2), .DATA_W(32)) bus ();

  finalproj_soc_pio_arbiter #(.N_REQ(N), .ADDR_W(2), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_if           (bus),
    .pio_address_o    (pio_addr),
    .pio_chipselect_o (pio_cs),
    .pio_write_n_o    (pio_wn),
    .pio_writedata_o  (pio_wdata),
    .pio_readdata_i   (pio_rdata)
`ifdef PIO_ARB_LOCK_EN
    ,
    .lock_i           (lock)
`endif
  );

  always #5 clk = ~clk;

  // Zero-wait-state PIO slave model.
  always @(posedge clk) begin
    if (mem_init) begin
      pio_mem[0] <= 32'h0000_1234;
      pio_mem[1] <= 32'hCAFE_0001;
      pio_mem[2] <= 32'h0000_BEEF;
      pio_mem[3] <= 32'h55AA_55AA;
    end else if (pio_cs && !pio_wn) begin
      pio_mem[pio_addr] <= pio_wdata;
    end
  end
  assign pio_rdata = pio_mem[pio_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    mem_init = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    reset    = 1'b0;
    mem_init = 1'b0;
  endtask

  task automatic drive_idle();
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [5:0]  addr;
    logic [95:0] wdata;
    logic [2:0]  exp_ack;
    logic [2:0]  exp_gid;
    logic [1:0]  exp_addr;
    logic        exp_wn;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tv [8];

  // Transaction-level model state for the random phase.
  logic [31:0] m_mem [4];
  logic [31:0] m_rdata;
  int          m_ptr;
  logic        pend   [N];
  logic        p_wr   [N];
  logic [1:0]  p_addr [N];
  logic [31:0] p_wdata[N];

  initial begin
    tv[0] = '{3'b001, 3'b000, {2'd0, 2'd0, 2'd0}, {32'h0, 32'h0, 32'h0},
              3'b001, 3'd0, 2'd0, 1'b1, 32'h0, 32'h0000_1234};
    tv[1] = '{3'b010, 3'b010, {2'd0, 2'd0, 2'd0}, {32'h0, 32'h0000_2A5A, 32'h0},
              3'b010, 3'd1, 2'd0, 1'b0, 32'h0000_2A5A, 32'h0000_1234};
    tv[2] = '{3'b011, 3'b000, {2'd0, 2'd0, 2'd1}, {32'h0, 32'h0, 32'h0},
              3'b001, 3'd0, 2'd1, 1'b1, 32'h0, 32'hCAFE_0001};
    tv[3] = '{3'b101, 3'b100, {2'd3, 2'd0, 2'd2}, {32'hFFFF_0000, 32'h0, 32'h0},
              3'b100, 3'd2, 2'd3, 1'b0, 32'hFFFF_0000, 32'hCAFE_0001};
    tv[4] = '{3'b110, 3'b000, {2'd0, 2'd3, 2'd0}, {32'h0, 32'h0, 32'h0},
              3'b010, 3'd1, 2'd3, 1'b1, 32'h0, 32'hFFFF_0000};
    tv[5] = '{3'b111, 3'b001, {2'd0, 2'd2, 2'd1}, {32'h0, 32'h0, 32'h0000_0011},
              3'b100, 3'd2, 2'd0, 1'b1, 32'h0, 32'h0000_2A5A};
    tv[6] = '{3'b111, 3'b001, {2'd0, 2'd2, 2'd1}, {32'h0, 32'h0, 32'h0000_0011},
              3'b001, 3'd0, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_2A5A};
    tv[7] = '{3'b010, 3'b000, {2'd0, 2'd1, 2'd0}, {32'h0, 32'h0, 32'h0},
              3'b010, 3'd1, 2'd1, 1'b1, 32'h0, 32'h0000_0011};

    drive_idle();
    do_reset(2);

    chk("rst_ack",   32'(bus.ack), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_gid",   32'(bus.grant_id), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_cs",    32'(pio_cs), 32'h0);
    chk("rst_wn",    32'(pio_wn), 32'h1);
    chk("rst_addr",  32'(pio_addr), 32'h0);
    chk("rst_wdata", pio_wdata, 32'h0);

    // Directed table: each row is one transaction started from IDLE.
    for (int v = 0; v < 8; v++) begin
      bus.req       = tv[v].req;
      bus.req_wr    = tv[v].wr;
      bus.req_addr  = tv[v].addr;
      bus.req_wdata = tv[v].wdata;
      step();
      chk("tv_issue_cs",    32'(pio_cs), 32'h1);
      chk("tv_issue_wn",    32'(pio_wn), 32'(tv[v].exp_wn));
      chk("tv_issue_addr",  32'(pio_addr), 32'(tv[v].exp_addr));
      chk("tv_issue_wdata", pio_wdata, tv[v].exp_wdata);
      chk("tv_issue_busy",  32'(bus.busy), 32'h1);
      chk("tv_issue_noack", 32'(bus.ack), 32'h0);
      step();
      chk("tv_ack",       32'(bus.ack), 32'(tv[v].exp_ack));
      chk("tv_gid",       32'(bus.grant_id), 32'(tv[v].exp_gid));
      chk("tv_rdata",     bus.rdata, tv[v].exp_rdata);
      chk("tv_ack_cs",    32'(pio_cs), 32'h0);
      chk("tv_ack_busy",  32'(bus.busy), 32'h1);
      drive_idle();
      step();
      chk("tv_idle_ack",   32'(bus.ack), 32'h0);
      chk("tv_idle_busy",  32'(bus.busy), 32'h0);
      chk("tv_rdata_hold", bus.rdata, tv[v].exp_rdata);
    end

    // Reset during ISSUE aborts the access and returns the pointer to 0.
    bus.req = 3'b001;
    step();
    chk("midrst_in_issue", 32'(pio_cs), 32'h1);
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_ack",  32'(bus.ack), 32'h0);
    chk("midrst_cs",   32'(pio_cs), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    step();
    step();
    chk("midrst_no_late_ack", 32'(bus.ack), 32'h0);
    bus.req = 3'b101;
    step();
    step();
    chk("midrst_ptr0_ack", 32'(bus.ack), 32'h1);
    drive_idle();
    step();

    // Contention: all requesters held, grants rotate 0,1,2,0 every 3 cycles.
    do_reset(2);
    bus.req    = 3'b111;
    bus.req_wr = 3'b111;
    for (int c = 1; c <= 12; c++) begin
      logic [2:0] exp_a;
      step();
      exp_a = (c % 3 == 2) ? 3'(1 << (((c - 2) / 3) % 3)) : 3'b000;
      chk("contention_ack", 32'(bus.ack), 32'(exp_a));
    end
    drive_idle();
    step();
    step();

`ifdef PIO_ARB_LOCK_EN
    begin
      int got [3];
      int n_got = 0;
      do_reset(2);
      bus.req = 3'b010;
      step();
      step();
      drive_idle();
      step();
      bus.req = 3'b101;
      lock    = 3'b100;
      for (int c = 0; c < 20 && n_got < 3; c++) begin
        step();
        if (bus.ack != 3'b000) begin
          got[n_got] = int'(bus.grant_id);
          n_got++;
          if (n_got == 2) lock = 3'b000;
        end
      end
      chk("lock_n_grants", 32'(n_got), 32'd3);
      chk("lock_grant0", 32'(got[0]), 32'd2);
      chk("lock_grant1", 32'(got[1]), 32'd2);
      chk("lock_grant2", 32'(got[2]), 32'd0);
      drive_idle();
      step();
      step();
    end
`endif

    // Randomized traffic against the transaction-level model.
    do_reset(2);
    m_mem[0] = 32'h0000_1234;
    m_mem[1] = 32'hCAFE_0001;
    m_mem[2] = 32'h0000_BEEF;
    m_mem[3] = 32'h55AA_55AA;
    m_rdata  = 32'h0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    for (int it = 0; it < 60; it++) begin
      int win, lat;
      logic any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]    = 1'b1;
          p_wr[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = 2'($urandom_range(0, 3));
          p_wdata[i] = $urandom;
        end
        any = any | pend[i];
      end
      if (!any) begin
        int k;
        k = $urandom_range(0, N - 1);
        pend[k]    = 1'b1;
        p_wr[k]    = 1'b0;
        p_addr[k]  = 2'($urandom_range(0, 3));
        p_wdata[k] = $urandom;
      end
      for (int i = 0; i < N; i++) begin
        bus.req[i]                  = pend[i];
        bus.req_wr[i]               = p_wr[i];
        bus.req_addr[i*2 +: 2]      = p_addr[i];
        bus.req_wdata[i*32 +: 32]   = p_wdata[i];
      end
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      lat = 0;
      do begin
        step();
        lat++;
      end while (bus.ack == 3'b000 && lat < 8);
      chk("rnd_latency", 32'(lat), 32'd2);
      chk("rnd_ack",     32'(bus.ack), 32'(1 << win));
      chk("rnd_gid",     32'(bus.grant_id), 32'(win));
      if (p_wr[win]) begin
        m_mem[p_addr[win]] = p_wdata[win];
      end else begin
        m_rdata = m_mem[p_addr[win]];
      end
      chk("rnd_rdata", bus.rdata, m_rdata);
      pend[win]   = 1'b0;
      bus.req[win] = 1'b0;
      m_ptr = (win + 1) % N;
      step();
      chk("rnd_mem", pio_mem[p_addr[win]], m_mem[p_addr[win]]);
    end

    drive_idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
